// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider (seq_div32).
//   DIV_WIDTH : default operand/quotient/remainder width
//   CNT_W     : iteration counter width for DIV_WIDTH
//   DZ_QUO    : quotient reported when the divisor is zero
//   state_t   : divider FSM state encoding (IDLE, CALC, FIX, DONE)
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    localparam logic [DIV_WIDTH-1:0] DZ_QUO = '1;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t FIX  = 2'd2;
    localparam state_t DONE = 2'd3;

endpackage

// File: rtl/div_step.sv
// One combinational iteration of restoring division.
// Ports:
//   r      in   WIDTH  partial remainder before this step
//   q      in   WIDTH  dividend/quotient shift register before this step
//   d      in   WIDTH  divisor
//   r_next out  WIDTH  partial remainder after this step
//   q_next out  WIDTH  quotient shift register after this step
// The remainder shifts left taking the dividend MSB, a WIDTH+1-bit ripple
// subtract of the divisor is tried, and its sign bit selects keep/restore.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] pr;
    logic [WIDTH:0] dd;
    logic [WIDTH:0] t;
    logic           neg;

    // The shifted remainder may reach 2*D-1, so it needs one extra bit.
    assign pr = {r, q[WIDTH-1]};
    assign dd = {1'b0, d};

    always_comb begin
        logic borrow;
        borrow = 1'b0;
        t      = '0;
        for (int unsigned i = 0; i < WIDTH + 1; i++) begin
            t[i]   = pr[i] ^ dd[i] ^ borrow;
            borrow = (~pr[i] & dd[i]) | (~(pr[i] ^ dd[i]) & borrow);
        end
    end

    assign neg = t[WIDTH];

    // On restore pr < D < 2^WIDTH, so dropping pr[WIDTH] loses nothing.
    assign r_next = neg ? pr[WIDTH-1:0] : t[WIDTH-1:0];
    assign q_next = {q[WIDTH-2:0], ~neg};

endmodule

// File: rtl/seq_div32.sv
// Multi-cycle restoring divider: quo/rem of A / B, one trial subtraction
// per clock, with a start/busy/done handshake.
// Configuration macro: SIGNED_DIV_EN (two's-complement signed division,
// truncating toward zero; undefined = unsigned only, V tied low).
// Ports:
//   clk    in   1      clock, all state on rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      request, accepted only in IDLE
//   A      in   WIDTH  dividend, sampled on the accepting edge
//   B      in   WIDTH  divisor, sampled on the accepting edge
//   busy   out  1      high from accept until DONE exits
//   done   out  1      one-cycle pulse, results valid
//   quo    out  WIDTH  quotient, held until the next result
//   rem    out  WIDTH  remainder, held until the next result
//   DZ     out  1      divide-by-zero flag
//   V      out  1      signed overflow flag (most-negative / -1)
module seq_div32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             DZ,
    output logic             V
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic             dz_q;

    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef SIGNED_DIV_EN
    logic a_neg;
    logic b_neg;
    logic ovf_in;
    logic neg_quo;
    logic neg_rem;
    logic ovf_q;

    assign a_neg  = A[WIDTH-1];
    assign b_neg  = B[WIDTH-1];
    // The most-negative value negates to itself, which is exactly its
    // unsigned magnitude, so no special case is needed here.
    assign a_mag  = a_neg ? -A : A;
    assign b_mag  = b_neg ? -B : B;
    assign ovf_in = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
`else
    assign a_mag = A;
    assign b_mag = B;
    assign V     = 1'b0;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (r_q),
        .q      (q_q),
        .d      (d_q),
        .r_next (step_r),
        .q_next (step_q)
    );

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            dz_q  <= 1'b0;
            quo   <= '0;
            rem   <= '0;
            DZ    <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            ovf_q   <= 1'b0;
            V       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r_q  <= '0;
                        d_q  <= b_mag;
                        cnt  <= '0;
                        dz_q <= (B == '0);
`ifdef SIGNED_DIV_EN
                        neg_quo <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        ovf_q   <= ovf_in;
`endif
                        // Divide-by-zero reports the raw dividend as the
                        // remainder, so keep A unmodified and skip CALC.
                        if (B == '0) begin
                            q_q   <= A;
                            state <= FIX;
                        end else begin
                            q_q   <= a_mag;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_q <= step_r;
                    q_q <= step_q;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz_q) begin
                        quo <= '1;
                        rem <= q_q;
                        DZ  <= 1'b1;
`ifdef SIGNED_DIV_EN
                        V   <= 1'b0;
`endif
                    end else begin
`ifdef SIGNED_DIV_EN
                        quo <= neg_quo ? -q_q : q_q;
                        rem <= neg_rem ? -r_q : r_q;
                        V   <= ovf_q;
`else
                        quo <= q_q;
                        rem <= r_q;
`endif
                        DZ  <= 1'b0;
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
